mem_wb_reg: RTL and testbench
=============================

Name: mem_wb_reg

Overview:
- MEM/WB pipeline register of the RISC-V core.
- Captures the four write-back candidates (ALU result, load data, PC+4, immediate) plus the 2-bit select, rd and write-enable from the MEM stage.
- Presents them registered to the downstream 4:1 write-back selector and register file.
- Owns the load-wait handshake with data memory: stalls the pipeline until load data returns, and inserts bubbles into WB while waiting.

Parameters:
- BIT_WIDTH, 32, datapath width of all data buses.
- REG_ADDR_W, 5, register-file address width.
- TIMEOUT_CYCLES, 255, load-wait limit in cycles. Used only when MEM_WB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  MEM-stage instruction valid.
- ex_alu_result  in  BIT_WIDTH  ALU result.
- ex_pc_plus4  in  BIT_WIDTH  PC+4 for JAL/JALR link.
- ex_imm  in  BIT_WIDTH  immediate for LUI.
- ex_rd  in  REG_ADDR_W  destination register.
- ex_reg_we  in  1  instruction writes rd.
- ex_wb_sel  in  2  00 ALU, 01 mem, 10 PC+4, 11 imm.
- ex_is_load  in  1  instruction is a load.
- dmem_rdata  in  BIT_WIDTH  load data.
- dmem_rvalid  in  1  dmem_rdata valid this cycle.
- flush  in  1  kill the instruction entering WB.
- wb_sel  out  2  registered select to the write-back selector.
- wb_in0  out  BIT_WIDTH  registered ALU result.
- wb_in1  out  BIT_WIDTH  registered load data.
- wb_in2  out  BIT_WIDTH  registered PC+4.
- wb_in3  out  BIT_WIDTH  registered immediate.
- wb_rd  out  REG_ADDR_W  registered rd.
- wb_reg_we  out  1  register-file write enable, qualified.
- wb_valid  out  1  WB instruction valid.
- mem_stall  out  1  hold IF..MEM stages this cycle.
- mem_err  out  1  load timeout flag, sticky.

Behaviour:
- Reset (async, immediate):
  - All wb_* outputs = 0, including wb_valid and wb_reg_we.
  - state = IDLE, mem_stall = 0, mem_err = 0, hold registers = 0.
- wb_reg_we = we_q & wb_valid & (wb_rd != 0). Never asserted for x0.
- State IDLE:
  - ex_valid=0 → next cycle bubble: wb_valid=0. Data registers may update freely.
  - ex_valid=1, non-load, or load with dmem_rvalid=1 same cycle → all fields latched, wb_valid=flush?0:1. Latency 1 cycle. wb_in1 takes dmem_rdata when rvalid, else holds its previous value.
  - ex_valid=1, ex_is_load=1, dmem_rvalid=0 → latch ex_* into hold registers, go to WAIT, wb_valid=0 next cycle. Record flush_pend = flush.
- mem_stall is combinational: 1 in IDLE when (ex_valid & ex_is_load & !dmem_rvalid); 1 throughout WAIT except the cycle dmem_rvalid=1.
  - Upstream holds ex_* stable while mem_stall=1; this block ignores ex_* in WAIT.
- State WAIT:
  - dmem_rvalid=0 → stay, wb_valid=0.
  - flush during WAIT → sets flush_pend.
  - dmem_rvalid=1 → output hold registers plus wb_in1=dmem_rdata, wb_valid = !(flush_pend | flush), then go to IDLE.
  - The next instruction is accepted from ex_* in the cycle after mem_stall drops.
- Flush in IDLE bubbles only the instruction being captured that cycle. It never cancels an outstanding memory transaction.
- dmem_rvalid in IDLE with ex_is_load=0 is ignored.
- Reset mid-WAIT → IDLE immediately. A later stray rvalid is ignored per the rule above.

Optional Feature:
- MEM_WB_TIMEOUT_EN defined:
  - An 8..32-bit wait counter clears on WAIT entry and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES with no rvalid: go to IDLE, emit a bubble, deassert mem_stall, set mem_err=1. mem_err holds until rst.
- Not defined: no counter; mem_err tied 0; WAIT lasts indefinitely.

Test Plan:
1. Reset then ALU op: ex_valid=1, alu=0x1234, sel=00, rd=5, we=1 → next cycle wb_valid=1, wb_in0=0x1234, wb_sel=00, wb_reg_we=1, mem_stall never 1.
2. Load hit: ex_is_load=1, sel=01, dmem_rvalid=1, rdata=0xDEADBEEF → next cycle wb_in1=0xDEADBEEF, wb_valid=1, zero stall cycles.
3. Load miss with rvalid 3 cycles later (rdata=0xCAFE0001) → mem_stall=1 for 3 cycles, wb_valid=0 for 3 cycles, then wb_valid=1, wb_in1=0xCAFE0001, rd from hold registers.
4. Write to x0: rd=0, we=1 → wb_valid=1, wb_reg_we=0. Flush in IDLE on a valid op → wb_valid=0 next cycle.
5. Flush during WAIT, rvalid 2 cycles later → stall released on the rvalid cycle, wb_valid stays 0; following instruction proceeds normally.
6. rst asserted mid-WAIT, asynchronously between edges → outputs 0 before next edge. With MEM_WB_TIMEOUT_EN and TIMEOUT_CYCLES=4, no rvalid → mem_err=1 after 4 WAIT cycles, stall drops, mem_err stays until rst.

Source files
------------

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with load-wait handshake toward data memory.
// Optional load timeout with sticky error flag: define MEM_WB_TIMEOUT_EN.
module mem_wb_reg #(
    parameter int BIT_WIDTH      = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [BIT_WIDTH-1:0]  ex_alu_result,
    input  logic [BIT_WIDTH-1:0]  ex_pc_plus4,
    input  logic [BIT_WIDTH-1:0]  ex_imm,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_we,
    input  logic [1:0]            ex_wb_sel,
    input  logic                  ex_is_load,
    input  logic [BIT_WIDTH-1:0]  dmem_rdata,
    input  logic                  dmem_rvalid,
    input  logic                  flush,
    output logic [1:0]            wb_sel,
    output logic [BIT_WIDTH-1:0]  wb_in0,
    output logic [BIT_WIDTH-1:0]  wb_in1,
    output logic [BIT_WIDTH-1:0]  wb_in2,
    output logic [BIT_WIDTH-1:0]  wb_in3,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_we,
    output logic                  wb_valid,
    output logic                  mem_stall,
    output logic                  mem_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [BIT_WIDTH-1:0]  hold_alu;
    logic [BIT_WIDTH-1:0]  hold_pc4;
    logic [BIT_WIDTH-1:0]  hold_imm;
    logic [REG_ADDR_W-1:0] hold_rd;
    logic                  hold_we;
    logic [1:0]            hold_sel;
    logic                  flush_pend;
    logic                  we_q;

    logic accept;
    logic miss;
    logic done;
    logic timeout_hit;

    assign accept = (state_q == S_IDLE) & ex_valid &
                    (~ex_is_load | dmem_rvalid);
    assign miss   = (state_q == S_IDLE) & ex_valid &
                    ex_is_load & ~dmem_rvalid;
    assign done   = (state_q == S_WAIT) & dmem_rvalid;

`ifdef MEM_WB_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = (CW_RAW < 8) ? 8 : CW_RAW;

    logic [CW-1:0] cnt_q;

    assign timeout_hit = (state_q == S_WAIT) & ~dmem_rvalid &
                         (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            mem_err <= 1'b0;
        end else begin
            if (miss)
                cnt_q <= '0;
            else if (state_q == S_WAIT && !dmem_rvalid)
                cnt_q <= cnt_q + 1'b1;
            if (timeout_hit)
                mem_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (miss) begin
                    state_d   = S_WAIT;
                    mem_stall = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid || timeout_hit)
                    state_d = S_IDLE;
                else
                    mem_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_sel     <= '0;
            wb_in0     <= '0;
            wb_in1     <= '0;
            wb_in2     <= '0;
            wb_in3     <= '0;
            wb_rd      <= '0;
            we_q       <= 1'b0;
            wb_valid   <= 1'b0;
            hold_alu   <= '0;
            hold_pc4   <= '0;
            hold_imm   <= '0;
            hold_rd    <= '0;
            hold_we    <= 1'b0;
            hold_sel   <= '0;
            flush_pend <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (accept) begin
                wb_sel   <= ex_wb_sel;
                wb_in0   <= ex_alu_result;
                wb_in2   <= ex_pc_plus4;
                wb_in3   <= ex_imm;
                wb_rd    <= ex_rd;
                we_q     <= ex_reg_we;
                wb_valid <= ~flush;
                // Stray rvalid alongside a non-load must not disturb load data
                if (ex_is_load)
                    wb_in1 <= dmem_rdata;
            end
            if (miss) begin
                hold_alu   <= ex_alu_result;
                hold_pc4   <= ex_pc_plus4;
                hold_imm   <= ex_imm;
                hold_rd    <= ex_rd;
                hold_we    <= ex_reg_we;
                hold_sel   <= ex_wb_sel;
                flush_pend <= flush;
            end
            if (state_q == S_WAIT && !dmem_rvalid && flush)
                flush_pend <= 1'b1;
            if (done) begin
                wb_sel     <= hold_sel;
                wb_in0     <= hold_alu;
                wb_in1     <= dmem_rdata;
                wb_in2     <= hold_pc4;
                wb_in3     <= hold_imm;
                wb_rd      <= hold_rd;
                we_q       <= hold_we;
                wb_valid   <= ~(flush_pend | flush);
                flush_pend <= 1'b0;
            end
        end
    end

    assign wb_reg_we = we_q & wb_valid & (wb_rd != '0);

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed bench for mem_wb_reg: vector table plus multi-cycle sequences.
// Timeout sequence is compiled in when MEM_WB_TIMEOUT_EN is defined.
module tb_mem_wb_reg;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_pc_plus4;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic [1:0]  ex_wb_sel;
    logic        ex_is_load;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        flush;
    logic [1:0]  wb_sel;
    logic [31:0] wb_in0;
    logic [31:0] wb_in1;
    logic [31:0] wb_in2;
    logic [31:0] wb_in3;
    logic [4:0]  wb_rd;
    logic        wb_reg_we;
    logic        wb_valid;
    logic        mem_stall;
    logic        mem_err;

    int ncmp = 0;
    int nerr = 0;

    mem_wb_reg #(
        .BIT_WIDTH(32),
        .REG_ADDR_W(5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ex_valid(ex_valid),
        .ex_alu_result(ex_alu_result),
        .ex_pc_plus4(ex_pc_plus4),
        .ex_imm(ex_imm),
        .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we),
        .ex_wb_sel(ex_wb_sel),
        .ex_is_load(ex_is_load),
        .dmem_rdata(dmem_rdata),
        .dmem_rvalid(dmem_rvalid),
        .flush(flush),
        .wb_sel(wb_sel),
        .wb_in0(wb_in0),
        .wb_in1(wb_in1),
        .wb_in2(wb_in2),
        .wb_in3(wb_in3),
        .wb_rd(wb_rd),
        .wb_reg_we(wb_reg_we),
        .wb_valid(wb_valid),
        .mem_stall(mem_stall),
        .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] alu, pc4, imm;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic        ld;
        logic [31:0] rdata;
        logic        rv, fl;
        logic        e_v, e_we, chk;
        logic [31:0] e0, e1, e2, e3;
        logic [1:0]  e_sel;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] alu,
                          input logic [31:0] pc4, input logic [31:0] imm,
                          input logic [4:0] rd, input logic we,
                          input logic [1:0] sel, input logic ld,
                          input logic [31:0] rdata, input logic rv,
                          input logic fl);
        ex_valid      = v;
        ex_alu_result = alu;
        ex_pc_plus4   = pc4;
        ex_imm        = imm;
        ex_rd         = rd;
        ex_reg_we     = we;
        ex_wb_sel     = sel;
        ex_is_load    = ld;
        dmem_rdata    = rdata;
        dmem_rvalid   = rv;
        flush         = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        logic v, logic [31:0] alu, logic [31:0] pc4, logic [31:0] imm,
        logic [4:0] rd, logic we, logic [1:0] sel, logic ld,
        logic [31:0] rdata, logic rv, logic fl,
        logic e_v, logic e_we, logic chk_d,
        logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
        logic [31:0] e3, logic [1:0] e_sel, logic [4:0] e_rd);
        vec_t x;
        x.v = v; x.alu = alu; x.pc4 = pc4; x.imm = imm;
        x.rd = rd; x.we = we; x.sel = sel; x.ld = ld;
        x.rdata = rdata; x.rv = rv; x.fl = fl;
        x.e_v = e_v; x.e_we = e_we; x.chk = chk_d;
        x.e0 = e0; x.e1 = e1; x.e2 = e2; x.e3 = e3;
        x.e_sel = e_sel; x.e_rd = e_rd;
        return x;
    endfunction

    initial begin
        tbl.push_back(mk(1, 32'h1234, 32'h4, 0, 5, 1, 2'd0, 0, 0, 0, 0,
                         1, 1, 1, 32'h1234, 0, 32'h4, 0, 2'd0, 5));
        tbl.push_back(mk(1, 32'h100, 32'h8, 0, 6, 1, 2'd1, 1,
                         32'hDEADBEEF, 1, 0,
                         1, 1, 1, 32'h100, 32'hDEADBEEF, 32'h8, 0, 2'd1, 6));
        tbl.push_back(mk(1, 32'h55, 32'hC, 0, 0, 1, 2'd0, 0, 0, 0, 0,
                         1, 0, 1, 32'h55, 32'hDEADBEEF, 32'hC, 0, 2'd0, 0));
        tbl.push_back(mk(1, 32'h77, 32'h10, 0, 7, 1, 2'd0, 0, 0, 0, 1,
                         0, 0, 1, 32'h77, 32'hDEADBEEF, 32'h10, 0, 2'd0, 7));
        tbl.push_back(mk(0, 32'hFFFF, 32'h14, 0, 9, 1, 2'd0, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
        tbl.push_back(mk(1, 32'h9, 32'h40, 0, 3, 1, 2'd2, 0,
                         32'h11111111, 1, 0,
                         1, 1, 1, 32'h9, 32'hDEADBEEF, 32'h40, 0, 2'd2, 3));
        tbl.push_back(mk(1, 0, 32'h44, 32'hABCDE000, 31, 1, 2'd3, 0, 0, 0, 0,
                         1, 1, 1, 0, 32'hDEADBEEF, 32'h44, 32'hABCDE000,
                         2'd3, 31));
        tbl.push_back(mk(1, 32'h2, 32'h48, 0, 4, 0, 2'd0, 0, 0, 0, 0,
                         1, 0, 1, 32'h2, 32'hDEADBEEF, 32'h48, 0, 2'd0, 4));
        tbl.push_back(mk(1, 32'h3, 32'h4C, 0, 8, 1, 2'd1, 1,
                         32'h12345678, 1, 1,
                         0, 0, 1, 32'h3, 32'h12345678, 32'h4C, 0, 2'd1, 8));

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_valid", 32'(wb_valid), 0);
        chk("rst_we", 32'(wb_reg_we), 0);
        chk("rst_in0", wb_in0, 0);
        chk("rst_in1", wb_in1, 0);
        chk("rst_in2", wb_in2, 0);
        chk("rst_in3", wb_in3, 0);
        chk("rst_rd", 32'(wb_rd), 0);
        chk("rst_sel", 32'(wb_sel), 0);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_err", 32'(mem_err), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            vec_t x;
            x = tbl[i];
            set_in(x.v, x.alu, x.pc4, x.imm, x.rd, x.we, x.sel, x.ld,
                   x.rdata, x.rv, x.fl);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(mem_stall), 0);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(wb_valid), 32'(x.e_v));
            chk($sformatf("v%0d_we", i), 32'(wb_reg_we), 32'(x.e_we));
            if (x.chk) begin
                chk($sformatf("v%0d_in0", i), wb_in0, x.e0);
                chk($sformatf("v%0d_in1", i), wb_in1, x.e1);
                chk($sformatf("v%0d_in2", i), wb_in2, x.e2);
                chk($sformatf("v%0d_in3", i), wb_in3, x.e3);
                chk($sformatf("v%0d_sel", i), 32'(wb_sel), 32'(x.e_sel));
                chk($sformatf("v%0d_rd", i), 32'(wb_rd), 32'(x.e_rd));
            end
        end

        // load miss, data three cycles later; ex_* scrambled in WAIT
        set_in(1, 32'hA0, 32'h50, 0, 9, 1, 2'd1, 1, 0, 0, 0);
        #1 chk("miss_stall0", 32'(mem_stall), 1);
        tick();
        chk("miss_valid0", 32'(wb_valid), 0);
        for (int i = 0; i < 2; i++) begin
            set_in(1, 32'hBAD, 0, 0, 12, 0, 2'd0, 1, 0, 0, 0);
            #1 chk($sformatf("miss_stall_w%0d", i), 32'(mem_stall), 1);
            tick();
            chk($sformatf("miss_valid_w%0d", i), 32'(wb_valid), 0);
        end
        set_in(1, 32'hBAD, 0, 0, 12, 0, 2'd0, 1, 32'hCAFE0001, 1, 0);
        #1 chk("miss_stall_rv", 32'(mem_stall), 0);
        tick();
        chk("miss_valid", 32'(wb_valid), 1);
        chk("miss_in1", wb_in1, 32'hCAFE0001);
        chk("miss_in0", wb_in0, 32'hA0);
        chk("miss_in2", wb_in2, 32'h50);
        chk("miss_rd", 32'(wb_rd), 9);
        chk("miss_sel", 32'(wb_sel), 1);
        chk("miss_we", 32'(wb_reg_we), 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("miss_after", 32'(wb_valid), 0);

        // flush while waiting kills the load result
        set_in(1, 32'hB0, 32'h54, 0, 10, 1, 2'd1, 1, 0, 0, 0);
        #1 chk("fw_stall0", 32'(mem_stall), 1);
        tick();
        set_in(1, 32'hB0, 32'h54, 0, 10, 1, 2'd1, 1, 0, 0, 1);
        #1 chk("fw_stall1", 32'(mem_stall), 1);
        tick();
        set_in(1, 32'hB0, 32'h54, 0, 10, 1, 2'd1, 1, 0, 0, 0);
        #1 chk("fw_stall2", 32'(mem_stall), 1);
        tick();
        set_in(1, 32'hB0, 32'h54, 0, 10, 1, 2'd1, 1, 32'h77, 1, 0);
        #1 chk("fw_stall_rv", 32'(mem_stall), 0);
        tick();
        chk("fw_valid", 32'(wb_valid), 0);
        chk("fw_we", 32'(wb_reg_we), 0);
        set_in(1, 32'h5A, 32'h58, 0, 2, 1, 2'd0, 0, 0, 0, 0);
        #1 chk("fw_next_stall", 32'(mem_stall), 0);
        tick();
        chk("fw_next_valid", 32'(wb_valid), 1);
        chk("fw_next_in0", wb_in0, 32'h5A);
        chk("fw_next_rd", 32'(wb_rd), 2);
        chk("fw_next_we", 32'(wb_reg_we), 1);

        // asynchronous reset in the middle of WAIT
        set_in(1, 32'hC0, 32'h5C, 0, 11, 1, 2'd1, 1, 0, 0, 0);
        tick();
        #2;
        rst = 1'b1;
        ex_valid = 1'b0;
        #1;
        chk("arst_valid", 32'(wb_valid), 0);
        chk("arst_in0", wb_in0, 0);
        chk("arst_rd", 32'(wb_rd), 0);
        chk("arst_stall", 32'(mem_stall), 0);
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h99, 1, 0);
        #1 chk("stray_stall", 32'(mem_stall), 0);
        tick();
        chk("stray_valid", 32'(wb_valid), 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        set_in(1, 32'hD0, 32'h60, 0, 13, 1, 2'd1, 1, 0, 0, 0);
        #1 chk("to_stall0", 32'(mem_stall), 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef MEM_WB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("to_stall_w%0d", i), 32'(mem_stall), 1);
            chk($sformatf("to_err_w%0d", i), 32'(mem_err), 0);
            tick();
        end
        #1 chk("to_stall_drop", 32'(mem_stall), 0);
        tick();
        chk("to_err", 32'(mem_err), 1);
        chk("to_valid", 32'(wb_valid), 0);
        tick();
        tick();
        chk("to_err_sticky", 32'(mem_err), 1);
        chk("to_stall_idle", 32'(mem_stall), 0);
        rst = 1'b1;
        #1 chk("to_err_rst", 32'(mem_err), 0);
        @(negedge clk);
        rst = 1'b0;
`else
        for (int i = 0; i < 6; i++) begin
            #1 chk($sformatf("nt_stall_w%0d", i), 32'(mem_stall), 1);
            chk($sformatf("nt_err_w%0d", i), 32'(mem_err), 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h600D, 1, 0);
        #1 chk("nt_stall_rv", 32'(mem_stall), 0);
        tick();
        chk("nt_valid", 32'(wb_valid), 1);
        chk("nt_in1", wb_in1, 32'h600D);
        chk("nt_rd", 32'(wb_rd), 13);
        chk("nt_err", 32'(mem_err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
